mem_port_arbiter: RTL

//  Shares one single-ported word memory (async read, write on clk edge) between two requesters.

---
 rtl/mem_port_arbiter.sv | 81 ++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-priority (port 1) arbiter with a starvation guard for port 0,
// sharing one single-ported word memory; alignment and range checks, registered read data.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;
  logic starved, we, legal, ok, rv0_q, rv1_q, err0_q, err1_q;
  logic [ADDR_W-1:0] addr, widx;
  logic [DATA_W-1:0] wdata;
  always_comb begin
    starved = starve_cnt >= CW'(STARVE_MAX);
    p0_gnt = !rst && p0_req && (!p1_req || starved);
    p1_gnt = !rst && p1_req && !p0_gnt;
    busy = !rst && p0_req && p1_req;
    addr = p1_gnt ? p1_addr : p0_addr;
    we = p1_gnt ? p1_we : p0_we;
    wdata = p1_gnt ? p1_wdata : p0_wdata;
    widx = addr >> 2;
    legal = addr[1:0] == 2'b00 && widx < ADDR_W'(DEPTH);
    ok = (p0_gnt || p1_gnt) && legal;
    mem_raddr = ok ? widx : '0;
    mem_waddr = ok ? widx : '0;
    mem_wdata = ok ? wdata : '0;
    mem_wen = ok && we;
    mem_ren = ok && !we;
  end
  // Responses captured before a reset edge must not surface while reset is held.
  assign p0_rvalid = rv0_q && !rst;
  assign p1_rvalid = rv1_q && !rst;
  assign p0_err = err0_q && !rst;
  assign p1_err = err1_q && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      starve_cnt <= (p0_req && !p0_gnt) ? (starved ? starve_cnt : starve_cnt + CW'(1)) : '0;
      rv0_q <= p0_gnt && !we;
      rv1_q <= p1_gnt && !we;
      err0_q <= p0_gnt && !legal;
      err1_q <= p1_gnt && !legal;
      if (p0_gnt && !we) p0_rdata <= legal ? mem_rdata : '0;
      if (p1_gnt && !we) p1_rdata <= legal ? mem_rdata : '0;
    end
  end
endmodule
